// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider: one quotient bit per clock, one operation in flight,
// valid/ready handshake on both the operand and the result side.
module seq_restoring_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero,
    output logic                  busy
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [DIVIDEND_W-1:0] shreg;
    logic [DIVISOR_W-1:0]  divisor_q;
    logic [DIVISOR_W:0]    part;
    logic [CNT_W-1:0]      cnt;

    logic                  accept;
    logic                  consume;
    logic                  zero_div;
    logic                  last_step;
    logic [DIVISOR_W:0]    trial;
    logic                  qbit;
    logic [DIVISOR_W:0]    part_nxt;

    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign zero_div  = (divisor_q == '0);
    // A zero divisor spends a single BUSY cycle so its result appears one edge after accept.
    assign last_step = zero_div || (cnt == LAST_CNT);

    // Previous partial remainder is below the divisor, so its top bit is always zero.
    assign trial    = {part[DIVISOR_W-1:0], shreg[DIVIDEND_W-1]};
    assign qbit     = (trial >= {1'b0, divisor_q});
    assign part_nxt = qbit ? (trial - {1'b0, divisor_q}) : trial;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept)    state_nxt = BUSY;
            BUSY: if (last_step) state_nxt = DONE;
            DONE: if (consume)   state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            divisor_q <= '0;
            part      <= '0;
            cnt       <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                shreg     <= dividend;
                divisor_q <= divisor;
                part      <= '0;
                cnt       <= '0;
            end
        end else if (state == BUSY) begin
            shreg <= {shreg[DIVIDEND_W-2:0], qbit};
            part  <= part_nxt;
            cnt   <= cnt + 1'b1;
        end
    end

    // Result registers change only on the BUSY -> DONE edge and hold through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (state == BUSY && last_step) begin
            if (zero_div) begin
                quotient  <= '1;
                remainder <= shreg[DIVISOR_W-1:0];
                div_zero  <= 1'b1;
            end else begin
                quotient  <= {shreg[DIVIDEND_W-2:0], qbit};
                remainder <= part_nxt[DIVISOR_W-1:0];
                div_zero  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: the driver pushes expected results computed with
// plain / and %, and an independent monitor compares every presented result against the queue.
module tb_seq_restoring_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
        int unsigned   acc_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;
    logic          busy;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          accepted = 0;
    int          retired = 0;
    int          rdy_mode = 0;
    int unsigned cyc = 0;
    logic        prev_ov = 1'b0;

    seq_restoring_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consumer: always ready, randomly ready, or stalled.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Issue one operation, hold in_valid until accepted, and record its expected result.
    task automatic send(input logic [DW-1:0] a, input logic [VW-1:0] b);
        exp_t e;
        int   waitc = 0;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waitc++;
            if (waitc > 200) begin
                check("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        e.a       = a;
        e.b       = b;
        e.acc_cyc = cyc;
        if (b == 0) begin
            e.q  = '1;
            e.r  = a[VW-1:0];
            e.dz = 1'b1;
        end else begin
            e.q  = DW'(int'(a) / int'(b));
            e.r  = VW'(int'(a) % int'(b));
            e.dz = 1'b0;
        end
        sb.push_back(e);
        accepted++;
        in_valid = 1'b0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        check("drain_queue_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every cycle a result is presented; latency and invariant at first presentation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                check("in_ready_low_in_done", in_ready, 0);
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    e = sb[0];
                    if (!prev_ov) begin
                        check("latency", cyc - e.acc_cyc, e.dz ? 1 : DW);
                        if (e.b != 0) begin
                            check("invariant", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
                            check("rem_lt_divisor", remainder < e.b, 1);
                        end
                    end
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("div_zero", div_zero, e.dz);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        retired++;
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        int waitc;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_div_zero", div_zero, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", in_ready, 1);

        // Directed operations with an always-ready consumer
        rdy_mode = 0;
        send(8'd200, 4'd13);
        #1;
        check("busy_after_accept", busy, 1);
        drain();
        send(8'd255, 4'd15);
        send(8'd9, 4'd1);
        send(8'd0, 4'd7);
        send(8'd7, 4'd0);
        send(8'd10, 4'd3);
        drain();

        // Result back-pressure: outputs held, operand-side activity ignored
        rdy_mode = 2;
        send(8'd200, 4'd13);
        waitc = 0;
        while (!out_valid && waitc < 20) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        check("bp_out_valid_seen", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = DW'($urandom);
            divisor  = VW'($urandom);
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_out_valid_held", out_valid, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        drain();

        // Reset in the 3rd BUSY cycle aborts the operation
        send(8'd100, 4'd7);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_div_zero", div_zero, 0);
        sb.delete();
        accepted--;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_abort", in_ready, 1);
        repeat (12) @(posedge clk);
        #1;
        check("no_stale_out_valid", out_valid, 0);
        send(8'd100, 4'd7);
        drain();

        // Exhaustive operand sweep with random gaps on both sides
        rdy_mode = 1;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clk);
                    #1;
                end
                send(DW'(a), VW'(b));
            end
        end
        drain();
        check("one_result_per_accept", retired, accepted);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
